// File: rtl/width_pack_fifo.sv
// width_pack_fifo: packs RATIO narrow beats into one wide word and queues
// wide words in a DEPTH-entry first-word-fall-through FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid      narrow stream in; in_last flushes a partial word
//   in_last/in_ready
//   out_data/out_keep     head wide word and its per-lane keep mask
//   out_valid/out_ready   wide stream out
//   level                 wide words currently stored
module width_pack_fifo #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 8,
    parameter int DEPTH     = 16,
    parameter int LSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IN_WIDTH-1:0]           in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [IN_WIDTH*RATIO-1:0]     out_data,
    output logic [RATIO-1:0]              out_keep,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int LANE_W    = $clog2(RATIO);

    logic [LANE_W-1:0]    lane;
    logic [OUT_WIDTH-1:0] asm_data;
    logic [RATIO-1:0]     asm_keep;
    logic [OUT_WIDTH-1:0] merged_data;
    logic [RATIO-1:0]     merged_keep;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_q;

    logic [OUT_WIDTH-1:0] mem_data [DEPTH];
    logic [RATIO-1:0]     mem_keep [DEPTH];

    logic accept;
    logic commit;
    logic pop;

    // Current beat merged into the assembly word at its lane slot.
    always_comb begin
        merged_data = asm_data;
        merged_keep = asm_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i)) begin
                merged_data[(LSB_FIRST != 0 ? i : RATIO-1-i)*IN_WIDTH +: IN_WIDTH] = in_data;
                merged_keep[i] = 1'b1;
            end
        end
    end

    // Ready depends only on stored level, so a pop frees space
    // only after the edge.
    assign in_ready  = (level_q < LVL_W'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign commit    = accept & (in_last | (lane == LANE_W'(RATIO-1)));
    assign out_valid = (level_q != '0);
    assign pop       = out_valid & out_ready;
    assign level     = level_q;

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_keep = out_valid ? mem_keep[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_data[wr_ptr] <= merged_data;
            mem_keep[wr_ptr] <= merged_keep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane     <= '0;
            asm_data <= '0;
            asm_keep <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
        end else begin
            if (commit) begin
                lane     <= '0;
                asm_data <= '0;
                asm_keep <= '0;
                wr_ptr   <= wr_ptr + 1'b1;
            end else if (accept) begin
                lane     <= lane + 1'b1;
                asm_data <= merged_data;
                asm_keep <= merged_keep;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({commit, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: tb/tb_width_pack_fifo.sv
// tb_width_pack_fifo: directed checks of packing, flush, fill,
// wrap, lane order and mid-burst reset.
module tb_width_pack_fifo;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [255:0] out_data;
    logic [7:0]   out_keep;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   level;

    logic [7:0]   b_in_data;
    logic         b_in_valid;
    logic         b_in_last;
    logic         b_in_ready;
    logic [31:0]  b_out_data;
    logic [3:0]   b_out_keep;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [2:0]   b_level;

    int checks;
    int failures;

    width_pack_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    width_pack_fifo #(
        .IN_WIDTH  (8),
        .RATIO     (4),
        .DEPTH     (4),
        .LSB_FIRST (0)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_last   (b_in_last),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_keep  (b_out_keep),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .level     (b_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        int n;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 256'(in_ready), 256'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [255:0] fill_word(input int w);
        logic [255:0] v;
        v = '0;
        for (int l = 0; l < 8; l++) v[l*32 +: 32] = 32'(32'h100 * w + l);
        return v;
    endfunction

    initial begin
        logic [255:0] exp;
        int idx;
        checks   = 0;
        failures = 0;
        in_data = '0; in_valid = 0; in_last = 0; out_ready = 0;
        b_in_data = '0; b_in_valid = 0; b_in_last = 0; b_out_ready = 0;

        // reset state
        rst_n = 1'b0;
        #2;
        chk("rst_valid", 256'(out_valid), 256'd0);
        chk("rst_data", out_data, 256'd0);
        chk("rst_keep", 256'(out_keep), 256'd0);
        chk("rst_ready", 256'(in_ready), 256'd1);
        chk("rst_level", 256'(level), 256'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MSB-first lane order, narrow instance
        b_in_valid = 1'b1;
        b_in_data = 8'h11; @(posedge clk); #1;
        b_in_data = 8'h22; @(posedge clk); #1;
        b_in_data = 8'h33; @(posedge clk); #1;
        b_in_data = 8'h44; @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("b_full_data", 256'(b_out_data), 256'h11223344);
        chk("b_full_keep", 256'(b_out_keep), 256'hF);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("b_pop_valid", 256'(b_out_valid), 256'd0);
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_data = 8'hAA; @(posedge clk); #1;
        b_in_data = 8'hBB; b_in_last = 1'b1; @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("b_part_data", 256'(b_out_data), 256'hAABB0000);
        chk("b_part_keep", 256'(b_out_keep), 256'h3);
        b_out_ready = 1'b1;
        @(posedge clk); #1;

        // one full word, back-to-back beats
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) beat(32'(i + 1), 1'b0);
        exp = '0;
        for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'(i + 1);
        chk("full_valid", 256'(out_valid), 256'd1);
        chk("full_data", out_data, exp);
        chk("full_keep", 256'(out_keep), 256'hFF);
        @(posedge clk); #1;
        chk("full_gone", 256'(out_valid), 256'd0);
        chk("full_level", 256'(level), 256'd0);

        // in_last without in_valid is ignored
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        chk("idle_last", 256'(level), 256'd0);

        // partial flush
        out_ready = 1'b0;
        beat(32'hA, 1'b0);
        beat(32'hB, 1'b0);
        beat(32'hC, 1'b1);
        chk("part_data", out_data, 256'h0000000C_0000000B_0000000A);
        chk("part_keep", 256'(out_keep), 256'h07);
        out_ready = 1'b1;
        @(posedge clk); #1;
        beat(32'h5, 1'b1);
        chk("restart_data", out_data, 256'h5);
        chk("restart_keep", 256'(out_keep), 256'h01);
        @(posedge clk); #1;
        chk("restart_empty", 256'(out_valid), 256'd0);

        // fill to DEPTH, hold, then drain in order
        out_ready = 1'b0;
        for (int w = 0; w < 16; w++)
            for (int l = 0; l < 8; l++) beat(32'(32'h100 * w + l), 1'b0);
        chk("fill_level", 256'(level), 256'd16);
        chk("fill_ready", 256'(in_ready), 256'd0);
        in_data = 32'hDEAD; in_last = 1'b1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("held_level", 256'(level), 256'd16);
        chk("held_head", out_data, fill_word(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pop1_level", 256'(level), 256'd15);
        chk("pop1_ready", 256'(in_ready), 256'd1);
        chk("pop1_head", out_data, fill_word(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("sim_level", 256'(level), 256'd15);
        for (int w = 2; w < 16; w++) begin
            chk($sformatf("drain%0d", w), out_data, fill_word(w));
            @(posedge clk); #1;
        end
        chk("drain_dead", out_data, 256'hDEAD);
        chk("drain_dkeep", 256'(out_keep), 256'h01);
        @(posedge clk); #1;
        chk("drain_empty", 256'(out_valid), 256'd0);

        // streaming single-beat words: commit+pop at level 1, wrap
        idx = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) beat(32'(32'h5000 + i), 1'b1);
            end
            begin
                for (int c = 0; c < 200 && idx < 40; c++) begin
                    @(posedge clk); #1;
                    if (out_valid) begin
                        chk("stream_data", out_data, 256'(32'h5000 + idx));
                        chk("stream_level", 256'(level), 256'd1);
                        idx++;
                    end
                end
            end
        join
        chk("stream_count", 256'(idx), 256'd40);
        @(posedge clk); #1;
        chk("stream_empty", 256'(out_valid), 256'd0);

        // asynchronous reset mid-burst
        out_ready = 1'b0;
        for (int i = 0; i < 29; i++) beat(32'(32'h300 + i), 1'b0);
        chk("pre_rst_level", 256'(level), 256'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(out_valid), 256'd0);
        chk("mid_rst_level", 256'(level), 256'd0);
        chk("mid_rst_ready", 256'(in_ready), 256'd1);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) beat(32'(32'h71 + i), 1'b0);
        exp = '0;
        for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'(32'h71 + i);
        chk("post_rst_data", out_data, exp);
        chk("post_rst_keep", 256'(out_keep), 256'hFF);
        chk("post_rst_level", 256'(level), 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
